// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and the 4x4 legend helper for the keypad scanner.
// Used by keypad_scan_fifo and by downstream legend decode.
package keypad_pkg;

  localparam int KEY_CODE_W = 8;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } scan_state_t;

  typedef struct packed {
    logic                  rel;
    logic [KEY_CODE_W-1:0] code;
  } key_evt_t;

  function automatic logic [3:0] code_to_bcd4x4(
    input logic [3:0] code
  );
    logic [3:0] bcd;
    bcd = 4'h0;
    unique case (code)
      4'd0:  bcd = 4'h1;
      4'd1:  bcd = 4'h2;
      4'd2:  bcd = 4'h3;
      4'd3:  bcd = 4'hA;
      4'd4:  bcd = 4'h4;
      4'd5:  bcd = 4'h5;
      4'd6:  bcd = 4'h6;
      4'd7:  bcd = 4'hB;
      4'd8:  bcd = 4'h7;
      4'd9:  bcd = 4'h8;
      4'd10: bcd = 4'h9;
      4'd11: bcd = 4'hC;
      4'd12: bcd = 4'hE;
      4'd13: bcd = 4'h0;
      4'd14: bcd = 4'hF;
      4'd15: bcd = 4'hD;
    endcase
    return bcd;
  endfunction

endpackage

// File: rtl/keypad_scan_fifo_if.sv
// keypad_scan_fifo_if: valid/ready key-event stream.
// master = event producer, slave = consumer.
interface keypad_scan_fifo_if #(
  parameter int CODE_W = 4
);
  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              evt_release;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_release,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_release,
    output evt_ready
  );
endinterface

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: synchronous show-ahead FIFO with full/empty/drop flags.
// When empty, dout holds the last popped entry.
module keypad_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [W-1:0]  last_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = empty ? last_q : mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem[rd_q];
      end
      if (do_push && !do_pop)
        cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: row scanner, press/release debounce, event FIFO.
// Define KEYPAD_AUTOREPEAT_EN for repeat press events while held.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int N_ROWS          = 4,
  parameter int N_COLS          = 4,
  parameter int SCAN_DWELL      = 2,
  parameter int DEBOUNCE_CYCLES = 300,
  parameter int FIFO_DEPTH      = 8
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
`endif
) (
  input  logic              clk,
  input  logic              rst,
  output logic [N_ROWS-1:0] row_drive_n,
  input  logic [N_COLS-1:0] col_sense_n,
  keypad_scan_fifo_if.master evt,
  output logic              key_held,
  output logic              overflow,
  input  logic              overflow_clr
);
  localparam int CODE_W = $clog2(N_ROWS*N_COLS);
  localparam int ROW_W  = $clog2(N_ROWS);
  localparam int COL_W  = $clog2(N_COLS);
  localparam int DW_W   = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DWELL-1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES-1);

  scan_state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, row_nxt;
  logic [COL_W-1:0] col_q, col_d, low_idx;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [N_COLS-1:0] col_pat;
  logic all_ones;
  logic fsm_push, push, push_rel, pop;
  logic fifo_full, fifo_empty, drop;
  key_evt_t push_evt, head;

  assign all_ones = &col_sense_n;
  assign col_pat  = ~(N_COLS'(1) << col_q);
  assign row_nxt  = (row_q == ROW_W'(N_ROWS-1)) ? '0 : row_q + 1'b1;

  always_comb begin
    low_idx = '0;
    for (int c = 0; c < N_COLS; c++)
      if (!col_sense_n[c]) low_idx = COL_W'(c);
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    dwell_d  = dwell_q;
    db_d     = db_q;
    fsm_push = 1'b0;
    push_rel = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DW_LAST) begin
          dwell_d = '0;
          if ($onehot(~col_sense_n)) begin
            state_d = PRESS_DB;
            col_d   = low_idx;
            db_d    = '0;
          end else begin
            row_d = row_nxt;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (col_sense_n != col_pat) begin
          state_d = SCAN;
          row_d   = row_nxt;
          dwell_d = '0;
        end else if (db_q == DB_LAST) begin
          fsm_push = 1'b1;
          state_d  = HELD;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      HELD: begin
        if (all_ones) begin
          state_d = RELEASE_DB;
          db_d    = '0;
        end
      end
      RELEASE_DB: begin
        // a stray other key breaks the all-ones run without re-arming
        if (!col_sense_n[col_q]) begin
          state_d = HELD;
        end else if (!all_ones) begin
          db_d = '0;
        end else if (db_q == DB_LAST) begin
          fsm_push = 1'b1;
          push_rel = 1'b1;
          state_d  = SCAN;
          row_d    = row_nxt;
          dwell_d  = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      row_q   <= '0;
      col_q   <= '0;
      dwell_q <= '0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      db_q    <= db_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                           REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_lim;
  logic rpt_first_q, rpt_first_d, rpt_push;

  assign rpt_lim = rpt_first_q ? RPT_W'(REPEAT_DELAY-1)
                               : RPT_W'(REPEAT_PERIOD-1);

  always_comb begin
    rpt_d       = '0;
    rpt_first_d = 1'b1;
    rpt_push    = 1'b0;
    if (state_q == HELD && !all_ones) begin
      rpt_first_d = rpt_first_q;
      if (rpt_q == rpt_lim) begin
        rpt_push    = 1'b1;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign push = fsm_push | rpt_push;
`else
  assign push = fsm_push;
`endif

  always_comb begin
    push_evt      = '0;
    push_evt.rel  = push_rel;
    push_evt.code = KEY_CODE_W'(row_q * N_COLS + col_q);
  end

  assign pop = evt.evt_valid && evt.evt_ready;

  keypad_evt_fifo #(
    .W     ($bits(key_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_evt),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (drop)
  );

  logic unused_ok;
  assign unused_ok = ^{fifo_full, head.code};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  assign row_drive_n     = ~(N_ROWS'(1) << row_q);
  assign key_held        = (state_q == HELD) || (state_q == RELEASE_DB);
  assign evt.evt_valid   = !fifo_empty;
  assign evt.evt_code    = head.code[CODE_W-1:0];
  assign evt.evt_release = head.rel;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo: keypad matrix model driving the scanner,
// event-level reference model plus directed literal checks.
module tb_keypad_scan_fifo;
  import keypad_pkg::*;

  localparam int R     = 4;
  localparam int C     = 4;
  localparam int DW    = 2;
  localparam int DB    = 8;
  localparam int DEPTH = 4;

  typedef struct {
    bit rel;
    int code;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [R-1:0] row_drive_n;
  logic [C-1:0] col_sense_n;
  logic key_held;
  logic overflow;
  logic overflow_clr = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0] force_low = '0;

  keypad_scan_fifo_if #(.CODE_W(4)) bus ();

  keypad_scan_fifo #(
    .N_ROWS          (R),
    .N_COLS          (C),
    .SCAN_DWELL      (DW),
    .DEBOUNCE_CYCLES (DB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .row_drive_n  (row_drive_n),
    .col_sense_n  (col_sense_n),
    .evt          (bus),
    .key_held     (key_held),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  // passive switch matrix: a closed key shorts its row to its column
  always_comb begin
    col_sense_n = '1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (!row_drive_n[r] && keys[r*C+c]) col_sense_n[c] = 1'b0;
    col_sense_n = col_sense_n & ~force_low;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference model: phase 0 scan, 1 press debounce, 2 held, 3 release
  int  m_row, m_ph, m_t, m_col;
  bit  m_ovf;
  ev_t m_q[$];
  ev_t m_last;

  function automatic void model_reset();
    m_row = 0;
    m_ph  = 0;
    m_t   = 0;
    m_col = 0;
    m_ovf = 1'b0;
    m_q.delete();
    m_last = '{1'b0, 0};
  endfunction

  function automatic void model_step();
    bit push, prel, all1, dropped;
    int nz, zi, code;
    push = 0; prel = 0; dropped = 0;
    nz = 0; zi = 0;
    all1 = (col_sense_n == 4'hF);
    code = m_row * C + m_col;
    for (int c = 0; c < C; c++)
      if (!col_sense_n[c]) begin nz++; zi = c; end
    case (m_ph)
      0: if (m_t == DW-1) begin
           m_t = 0;
           if (nz == 1) begin m_ph = 1; m_col = zi; end
           else m_row = (m_row + 1) % R;
         end else m_t++;
      1: if (nz == 1 && zi == m_col) begin
           m_t++;
           if (m_t == DB) begin push = 1; m_ph = 2; end
         end else begin
           m_ph = 0; m_t = 0; m_row = (m_row + 1) % R;
         end
      2: if (all1) begin m_ph = 3; m_t = 0; end
      3: if (!col_sense_n[m_col]) m_ph = 2;
         else if (!all1) m_t = 0;
         else begin
           m_t++;
           if (m_t == DB) begin
             push = 1; prel = 1;
             m_ph = 0; m_t = 0; m_row = (m_row + 1) % R;
           end
         end
      default: m_ph = 0;
    endcase
    if (m_q.size() > 0 && bus.evt_ready) m_last = m_q.pop_front();
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back('{prel, code});
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (overflow_clr) m_ovf = 0;
  endfunction

  always @(negedge clk) begin
    ev_t h;
    if (rst) model_reset();
    if (m_q.size() > 0) h = m_q[0];
    else h = m_last;
    check("row_drive_n", int'(row_drive_n), 15 & ~(1 << m_row));
    check("evt_valid", int'(bus.evt_valid), int'(m_q.size() > 0));
    check("evt_code", int'(bus.evt_code), h.code);
    check("evt_release", int'(bus.evt_release), int'(h.rel));
    check("key_held", int'(key_held), int'(m_ph >= 2));
    check("overflow", int'(overflow), int'(m_ovf));
    if (!rst) model_step();
  end

  ev_t seen[$];

  always @(negedge clk) begin
    if (!rst && bus.evt_valid && bus.evt_ready)
      seen.push_back('{bus.evt_release, int'(bus.evt_code)});
  end

  function automatic ev_t seen_at(input int i);
    if (i < seen.size()) return seen[i];
    return '{1'b1, 99};
  endfunction

  task automatic check_seen(input string name, input int i,
                            input int code, input bit rel);
    ev_t e;
    e = seen_at(i);
    check({name, "_code"}, e.code, code);
    check({name, "_rel"}, int'(e.rel), int'(rel));
  endtask

  int exp_rows[10] = '{14, 14, 13, 13, 11, 11, 7, 7, 14, 14};

  initial begin
    bit found;
    bus.evt_ready = 1'b0;

    check("bcd_6", int'(code_to_bcd4x4(4'd6)), 6);
    check("bcd_3", int'(code_to_bcd4x4(4'd3)), 10);
    check("bcd_12", int'(code_to_bcd4x4(4'd12)), 14);
    check("bcd_13", int'(code_to_bcd4x4(4'd13)), 0);
    check("bcd_15", int'(code_to_bcd4x4(4'd15)), 13);

    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("scan_seq", int'(row_drive_n), exp_rows[i]);
      check("scan_idle_valid", int'(bus.evt_valid), 0);
    end

    tick(1);
    bus.evt_ready = 1'b1;
    keys[6] = 1'b1;
    tick(40);
    check("press_held", int'(key_held), 1);
    keys = '0;
    tick(40);
    check("release_held", int'(key_held), 0);
    check("pair_count", seen.size(), 2);
    check_seen("pair0", 0, 6, 1'b0);
    check_seen("pair1", 1, 6, 1'b1);

    seen.delete();
    force_low = 4'b0001;
    tick(3);
    force_low = '0;
    tick(20);
    check("glitch_events", seen.size(), 0);
    check("glitch_held", int'(key_held), 0);

    keys[8] = 1'b1;
    keys[9] = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (row_drive_n == 4'b1011) found = 1;
    end
    check("ghost_row2", int'(found), 1);
    repeat (2) @(negedge clk);
    check("ghost_row3", int'(row_drive_n), 7);
    tick(30);
    check("ghost_events", seen.size(), 0);
    check("ghost_held", int'(key_held), 0);
    keys = '0;
    tick(10);

    bus.evt_ready = 1'b0;
    keys[1] = 1'b1;  tick(40); keys = '0; tick(40);
    keys[15] = 1'b1; tick(40); keys = '0; tick(40);
    keys[10] = 1'b1; tick(40); keys = '0; tick(40);
    check("ovf_set", int'(overflow), 1);
    check("ovf_valid", int'(bus.evt_valid), 1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", int'(overflow), 0);
    bus.evt_ready = 1'b1;
    tick(10);
    check("drain_count", seen.size(), 4);
    check_seen("drain0", 0, 1, 1'b0);
    check_seen("drain1", 1, 1, 1'b1);
    check_seen("drain2", 2, 15, 1'b0);
    check_seen("drain3", 3, 15, 1'b1);

    bus.evt_ready = 1'b0;
    keys[2] = 1'b1; tick(30); keys = '0; tick(30);
    check("pre_rst_valid", int'(bus.evt_valid), 1);
    keys[15] = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (row_drive_n == 4'b0111) found = 1;
    end
    check("rst_row3", int'(found), 1);
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_row", int'(row_drive_n), 14);
    check("rst_valid", int'(bus.evt_valid), 0);
    check("rst_held", int'(key_held), 0);
    tick(1);
    rst = 1'b0;
    keys = '0;

    for (int it = 0; it < 60; it++) begin
      bit stall;
      int pick, dur;
      stall = ($urandom_range(0, 2) == 0);
      pick  = $urandom_range(0, 9);
      keys  = '0;
      if (pick < 6) begin
        keys[4'($urandom_range(0, 15))] = 1'b1;
      end else if (pick < 8) begin
        keys[4'($urandom_range(0, 15))] = 1'b1;
        keys[4'($urandom_range(0, 15))] = 1'b1;
      end
      dur = $urandom_range(1, 40);
      repeat (dur) begin
        if (stall) bus.evt_ready = ($urandom_range(0, 7) == 0);
        else       bus.evt_ready = ($urandom_range(0, 3) != 0);
        overflow_clr = ($urandom_range(0, 15) == 0);
        tick(1);
      end
    end
    keys = '0;
    overflow_clr = 1'b0;
    bus.evt_ready = 1'b1;
    tick(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
